reg_bank_param: RTL and testbench

Parametrised successor of the 16x8 register bank. NUM_REGS = 2**ADDR_W registers of DATA_W bits.
- R0 drives the external output. R1 and R2 drive the ALU operands. R3 and above are general purpose.
- Adds a per-register written-valid mask, a 2-cycle register swap sequencer and a multi-cycle sweep clear.
- Sits between CU/ALU and the external pins, fed by the same source mux (InA, InB, CUconst, ALUout, register read-back).

---
 rtl/reg_bank_param.sv | 120 ++++++++++++
 tb/tb_reg_bank_param.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_param.sv
// Parametrised register bank: R0 feeds the output pins, R1/R2 feed the ALU operands.
// Adds a written-valid mask, a two-cycle register swap and a one-register-per-cycle sweep clear.
module reg_bank_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      InA,
  input  logic [DATA_W-1:0]      InB,
  input  logic [DATA_W-1:0]      CUconst,
  input  logic [DATA_W-1:0]      ALUout,
  input  logic [2:0]             InMuxAdd,
  input  logic                   WE,
  input  logic [ADDR_W-1:0]      RegAdd,
  input  logic [ADDR_W-1:0]      OutMuxAdd,
  input  logic                   Swap,
  input  logic                   Clear,
  output logic                   Busy,
  output logic [DATA_W-1:0]      RdData,
  output logic [2**ADDR_W-1:0]   ValidMask,
  output logic [DATA_W-1:0]      Out,
  output logic [DATA_W-1:0]      ALUinA,
  output logic [DATA_W-1:0]      ALUinB
);

  localparam int unsigned NumRegs = 2**ADDR_W;

  typedef enum logic [1:0] {StIdle, StSwap1, StSwap2, StClear} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NumRegs];
  logic [DATA_W-1:0]   regs_d [NumRegs];
  logic [NumRegs-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0]   a_q, a_d, b_q, b_d, cnt_q, cnt_d;
  logic [DATA_W-1:0]   tmp_q, tmp_d;
  logic [DATA_W-1:0]   wr_src;

  assign RdData    = regs_q[OutMuxAdd];
  assign Out       = regs_q[0];
  assign ALUinA    = regs_q[1];
  assign ALUinB    = regs_q[2];
  assign ValidMask = valid_q;
  assign Busy      = (state_q != StIdle);

  // Sources 4..7 all select the read-back path (register-to-register move).
  always_comb begin
    case (InMuxAdd)
      3'd0:    wr_src = InA;
      3'd1:    wr_src = InB;
      3'd2:    wr_src = CUconst;
      3'd3:    wr_src = ALUout;
      default: wr_src = RdData;
    endcase
  end

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    tmp_d   = tmp_q;
    unique case (state_q)
      StIdle: begin
        if (Clear) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (Swap) begin
          state_d = StSwap1;
          a_d     = RegAdd;
          b_d     = OutMuxAdd;
        end else if (WE) begin
          regs_d[RegAdd]  = wr_src;
          valid_d[RegAdd] = 1'b1;
        end
      end
      StSwap1: begin
        tmp_d       = regs_q[a_q];
        regs_d[a_q] = regs_q[b_q];
        state_d     = StSwap2;
      end
      StSwap2: begin
        regs_d[b_q]  = tmp_q;
        valid_d[a_q] = valid_q[b_q];
        valid_d[b_q] = valid_q[a_q];
        state_d      = StIdle;
      end
      StClear: begin
        regs_d[cnt_q]  = '0;
        valid_d[cnt_q] = 1'b0;
        cnt_d          = cnt_q + ADDR_W'(1);
        if (&cnt_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      regs_q  <= '{default: '0};
      valid_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      tmp_q   <= '0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      tmp_q   <= tmp_d;
    end
  end

endmodule

// File: tb/tb_reg_bank_param.sv
// Randomised bench for reg_bank_param: an 8x16 instance and a 16x8 instance checked
// against an array model of the register file and valid mask.
module tb_reg_bank_param;

  logic clk = 1'b0;
  logic reset;
  always #50 clk = ~clk;

  // Instance A: DATA_W=8, ADDR_W=4
  logic [7:0]  a_ina, a_inb, a_cc, a_alu, a_rd, a_out, a_alua, a_alub;
  logic [2:0]  a_sel;
  logic        a_we, a_swap, a_clear, a_busy;
  logic [3:0]  a_radd, a_oadd;
  logic [15:0] a_vm;
  // Instance B: DATA_W=16, ADDR_W=3
  logic [15:0] b_ina, b_inb, b_cc, b_alu, b_rd, b_out, b_alua, b_alub;
  logic [2:0]  b_sel;
  logic        b_we, b_swap, b_clear, b_busy;
  logic [2:0]  b_radd, b_oadd;
  logic [7:0]  b_vm;

  reg_bank_param u_dut_a (
    .clk(clk), .reset(reset), .InA(a_ina), .InB(a_inb), .CUconst(a_cc), .ALUout(a_alu),
    .InMuxAdd(a_sel), .WE(a_we), .RegAdd(a_radd), .OutMuxAdd(a_oadd), .Swap(a_swap),
    .Clear(a_clear), .Busy(a_busy), .RdData(a_rd), .ValidMask(a_vm), .Out(a_out),
    .ALUinA(a_alua), .ALUinB(a_alub)
  );

  reg_bank_param #(.DATA_W(16), .ADDR_W(3)) u_dut_b (
    .clk(clk), .reset(reset), .InA(b_ina), .InB(b_inb), .CUconst(b_cc), .ALUout(b_alu),
    .InMuxAdd(b_sel), .WE(b_we), .RegAdd(b_radd), .OutMuxAdd(b_oadd), .Swap(b_swap),
    .Clear(b_clear), .Busy(b_busy), .RdData(b_rd), .ValidMask(b_vm), .Out(b_out),
    .ALUinA(b_alua), .ALUinB(b_alub)
  );

  logic [7:0]  ma [16];
  logic [15:0] mva;
  logic [15:0] mb [8];
  logic [7:0]  mvb;
  int n_vec = 0;
  int n_err = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) ma[i] = '0;
    for (int i = 0; i < 8; i++) mb[i] = '0;
    mva = '0;
    mvb = '0;
  endtask

  task automatic read_a(input int addr, output logic [7:0] d);
    a_oadd = addr[3:0];
    #1;
    d = a_rd;
  endtask

  task automatic read_b(input int addr, output logic [15:0] d);
    b_oadd = addr[2:0];
    #1;
    d = b_rd;
  endtask

  // One write on A; the model takes the source value by its select code.
  task automatic a_write(input int sel, input int addr, input int oaddr, input logic [7:0] val);
    a_ina = 8'($urandom); a_inb = 8'($urandom); a_cc = 8'($urandom); a_alu = 8'($urandom);
    case (sel)
      0: a_ina = val;
      1: a_inb = val;
      2: a_cc  = val;
      3: a_alu = val;
      default: ;
    endcase
    a_sel = sel[2:0]; a_radd = addr[3:0]; a_oadd = oaddr[3:0]; a_we = 1'b1;
    ma[addr] = (sel >= 4) ? ma[oaddr] : val;
    mva[addr] = 1'b1;
    tick();
    a_we = 1'b0;
  endtask

  task automatic b_write(input int sel, input int addr, input int oaddr, input logic [15:0] val);
    b_ina = 16'($urandom); b_inb = 16'($urandom); b_cc = 16'($urandom); b_alu = 16'($urandom);
    case (sel)
      0: b_ina = val;
      1: b_inb = val;
      2: b_cc  = val;
      3: b_alu = val;
      default: ;
    endcase
    b_sel = sel[2:0]; b_radd = addr[2:0]; b_oadd = oaddr[2:0]; b_we = 1'b1;
    mb[addr] = (sel >= 4) ? mb[oaddr] : val;
    mvb[addr] = 1'b1;
    tick();
    b_we = 1'b0;
  endtask

  task automatic test_reset();
    repeat (5) a_write($urandom_range(0, 3), $urandom_range(0, 15), 0, 8'($urandom));
    #10 reset = 1'b0;
    #1;
    model_clear();
    n_vec++; if (a_out !== 8'h00) begin n_err++; $display("FAIL reset_out got %h want 00", a_out); end
    n_vec++; if (a_alua !== 8'h00 || a_alub !== 8'h00) begin
      n_err++; $display("FAIL reset_alu got %h/%h want 00/00", a_alua, a_alub); end
    n_vec++; if (a_rd !== 8'h00) begin n_err++; $display("FAIL reset_rd got %h want 00", a_rd); end
    n_vec++; if (a_busy !== 1'b0 || a_vm !== 16'h0000) begin
      n_err++; $display("FAIL reset_state busy %b mask %h want 0/0000", a_busy, a_vm); end
    n_vec++; if (b_busy !== 1'b0 || b_vm !== 8'h00) begin
      n_err++; $display("FAIL reset_b busy %b mask %h want 0/00", b_busy, b_vm); end
    @(negedge clk) reset = 1'b1;
    a_write(0, 1, 0, 8'h5A);
    n_vec++; if (a_alua !== 8'h5A) begin n_err++; $display("FAIL first_write got %h want 5a", a_alua); end
    n_vec++; if (a_vm !== 16'h0002 || a_busy !== 1'b0) begin
      n_err++; $display("FAIL first_write_mask got %h busy %b want 0002/0", a_vm, a_busy); end
  endtask

  task automatic test_write_random();
    int oaddr;
    repeat (40) begin
      oaddr = $urandom_range(0, 15);
      a_write($urandom_range(0, 7), $urandom_range(0, 15), oaddr, 8'($urandom));
      n_vec++; if (a_out !== ma[0] || a_alua !== ma[1] || a_alub !== ma[2]) begin
        n_err++; $display("FAIL wr_outs got %h %h %h want %h %h %h",
                          a_out, a_alua, a_alub, ma[0], ma[1], ma[2]); end
      n_vec++; if (a_rd !== ma[oaddr]) begin
        n_err++; $display("FAIL wr_rd[%0d] got %h want %h", oaddr, a_rd, ma[oaddr]); end
      n_vec++; if (a_vm !== mva) begin n_err++; $display("FAIL wr_mask got %h want %h", a_vm, mva); end
    end
  endtask

  task automatic test_swap();
    logic [7:0] d3, d4, t;
    logic vt;
    int a, b, cyc;
    a_write(0, 3, 0, 8'h11);
    a_write(0, 4, 0, 8'h22);
    a_radd = 4'd3; a_oadd = 4'd4; a_swap = 1'b1;
    tick();
    n_vec++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL swap_busy1 got %b want 1", a_busy); end
    a_we = 1'b1; a_sel = 3'd0; a_ina = 8'hFF; a_radd = 4'd3;
    tick();
    n_vec++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL swap_busy2 got %b want 1", a_busy); end
    read_a(3, d3); read_a(4, d4);
    n_vec++; if (d3 !== 8'h22 || d4 !== 8'h22) begin
      n_err++; $display("FAIL swap_mid got %h/%h want 22/22", d3, d4); end
    tick();
    a_we = 1'b0; a_swap = 1'b0;
    n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL swap_done got %b want 0", a_busy); end
    read_a(3, d3); read_a(4, d4);
    n_vec++; if (d3 !== 8'h22 || d4 !== 8'h11) begin
      n_err++; $display("FAIL swap_result got %h/%h want 22/11", d3, d4); end
    ma[3] = 8'h22; ma[4] = 8'h11;
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 15);
      b = (i == 0) ? a : $urandom_range(0, 15);
      a_radd = a[3:0]; a_oadd = b[3:0]; a_swap = 1'b1;
      tick();
      a_swap = 1'b0; a_we = 1'b1; a_radd = 4'($urandom); a_ina = 8'($urandom);
      cyc = 0;
      while (a_busy && cyc < 10) begin cyc++; tick(); end
      a_we = 1'b0;
      n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL swap_len got %0d want 2", cyc); end
      t = ma[a]; ma[a] = ma[b]; ma[b] = t;
      vt = mva[a]; mva[a] = mva[b]; mva[b] = vt;
      read_a(a, d3); read_a(b, d4);
      n_vec++; if (d3 !== ma[a] || d4 !== ma[b]) begin
        n_err++; $display("FAIL swap_rand %0d<->%0d got %h/%h want %h/%h", a, b, d3, d4, ma[a], ma[b]); end
      n_vec++; if (a_vm !== mva) begin n_err++; $display("FAIL swap_mask got %h want %h", a_vm, mva); end
    end
  endtask

  task automatic test_move();
    a_write(1, 5, 0, 8'hC3);
    a_sel = 3'd5; a_oadd = 4'd5; a_radd = 4'd0; a_we = 1'b1;
    #1;
    n_vec++; if (a_out !== ma[0]) begin n_err++; $display("FAIL move_nobypass got %h want %h", a_out, ma[0]); end
    tick();
    a_we = 1'b0;
    ma[0] = 8'hC3; mva[0] = 1'b1;
    n_vec++; if (a_out !== 8'hC3) begin n_err++; $display("FAIL move_out got %h want c3", a_out); end
    n_vec++; if (a_vm !== mva) begin n_err++; $display("FAIL move_mask got %h want %h", a_vm, mva); end
  endtask

  task automatic test_clear();
    logic [7:0] d;
    logic [31:0] m;
    logic [15:0] exp_m;
    int cyc;
    for (int i = 0; i < 16; i++) a_write($urandom_range(0, 3), i, 0, 8'($urandom));
    for (int i = 0; i < 16; i++) begin
      read_a(i, d);
      n_vec++; if (d !== ma[i]) begin n_err++; $display("FAIL fill[%0d] got %h want %h", i, d, ma[i]); end
    end
    a_clear = 1'b1; a_we = 1'b1; a_swap = 1'b1; a_radd = 4'd9; a_oadd = 4'd2; a_sel = 3'd0;
    tick();
    a_clear = 1'b0; a_we = 1'b0; a_swap = 1'b0;
    cyc = 0;
    while (a_busy && cyc < 40) begin
      cyc++;
      m = (32'd1 << (cyc - 1)) - 32'd1;
      exp_m = mva & ~m[15:0];
      n_vec++; if (a_vm !== exp_m) begin
        n_err++; $display("FAIL clear_sweep cyc %0d got %h want %h", cyc, a_vm, exp_m); end
      tick();
    end
    n_vec++; if (cyc !== 16) begin n_err++; $display("FAIL clear_len got %0d want 16", cyc); end
    model_clear();
    n_vec++; if (a_vm !== 16'h0000) begin n_err++; $display("FAIL clear_mask got %h want 0000", a_vm); end
    for (int i = 0; i < 16; i++) begin
      read_a(i, d);
      n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL clear_reg[%0d] got %h want 00", i, d); end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [7:0] d;
    repeat (8) a_write($urandom_range(0, 3), $urandom_range(0, 15), 0, 8'($urandom) | 8'h01);
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    repeat (6) tick();
    n_vec++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL midclr_busy got %b want 1", a_busy); end
    #10 reset = 1'b0;
    #1;
    model_clear();
    n_vec++; if (a_busy !== 1'b0 || a_vm !== 16'h0000) begin
      n_err++; $display("FAIL midclr_reset busy %b mask %h want 0/0000", a_busy, a_vm); end
    for (int i = 0; i < 16; i++) begin
      read_a(i, d);
      n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL midclr_reg[%0d] got %h want 00", i, d); end
    end
    @(negedge clk) reset = 1'b1;
    a_write(2, 7, 0, 8'h3C);
    read_a(7, d);
    n_vec++; if (d !== 8'h3C || a_vm !== 16'h0080 || a_busy !== 1'b0) begin
      n_err++; $display("FAIL post_reset_cmd got %h mask %h busy %b want 3c/0080/0", d, a_vm, a_busy); end
  endtask

  task automatic test_wide();
    logic [15:0] d3, d4;
    int cyc;
    b_write(0, 1, 0, 16'hBEEF);
    n_vec++; if (b_alua !== 16'hBEEF || b_vm !== 8'h02 || b_busy !== 1'b0) begin
      n_err++; $display("FAIL wide_write got %h mask %h busy %b want beef/02/0", b_alua, b_vm, b_busy); end
    repeat (16) begin
      b_write($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      n_vec++; if (b_out !== mb[0] || b_alua !== mb[1] || b_alub !== mb[2] || b_vm !== mvb) begin
        n_err++; $display("FAIL wide_rand got %h %h %h %h want %h %h %h %h",
                          b_out, b_alua, b_alub, b_vm, mb[0], mb[1], mb[2], mvb); end
    end
    b_write(0, 3, 0, 16'hBEEF);
    b_write(3, 4, 0, 16'hCAFE);
    b_radd = 3'd3; b_oadd = 3'd4; b_swap = 1'b1;
    tick();
    b_swap = 1'b0; b_we = 1'b1; b_radd = 3'd3; b_sel = 3'd0;
    cyc = 0;
    while (b_busy && cyc < 10) begin cyc++; tick(); end
    b_we = 1'b0;
    n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL wide_swap_len got %0d want 2", cyc); end
    read_b(3, d3); read_b(4, d4);
    n_vec++; if (d3 !== 16'hCAFE || d4 !== 16'hBEEF) begin
      n_err++; $display("FAIL wide_swap got %h/%h want cafe/beef", d3, d4); end
    b_clear = 1'b1; b_we = 1'b1; b_swap = 1'b1;
    tick();
    b_clear = 1'b0; b_we = 1'b0; b_swap = 1'b0;
    cyc = 0;
    while (b_busy && cyc < 40) begin cyc++; tick(); end
    n_vec++; if (cyc !== 8) begin n_err++; $display("FAIL wide_clear_len got %0d want 8", cyc); end
    model_clear();
    n_vec++; if (b_vm !== 8'h00) begin n_err++; $display("FAIL wide_clear_mask got %h want 00", b_vm); end
    for (int i = 0; i < 8; i++) begin
      read_b(i, d3);
      n_vec++; if (d3 !== 16'h0000) begin n_err++; $display("FAIL wide_clear_reg[%0d] got %h want 0", i, d3); end
    end
  endtask

  initial begin
    reset = 1'b0;
    a_ina = '0; a_inb = '0; a_cc = '0; a_alu = '0; a_sel = '0;
    a_we = 1'b0; a_swap = 1'b0; a_clear = 1'b0; a_radd = '0; a_oadd = '0;
    b_ina = '0; b_inb = '0; b_cc = '0; b_alu = '0; b_sel = '0;
    b_we = 1'b0; b_swap = 1'b0; b_clear = 1'b0; b_radd = '0; b_oadd = '0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_write_random();
    test_swap();
    test_move();
    test_clear();
    test_reset_mid_clear();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
